// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expander (clk, reset, start, key_in -> busy, done, keys_ready; rd_round -> registered rd_key)
module aes_sbox32 (
   input  logic [31:0] a,
   output logic [31:0] y
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   for (genvar g = 0; g < 4; g++) begin : g_byte
      assign y[8*g +: 8] = SBOX[{~a[8*g +: 8], 3'b000} +: 8];
   end
endmodule

module aes_key_schedule #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                done,
   output logic                keys_ready,
   input  logic [3:0]          rd_round,
   output logic [127:0]        rd_key
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int TOTAL_WORDS = 4 * (NR + 1);
   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("KEY_BITS must be 128, 192 or 256");
   end
   typedef enum logic {IDLE, EXPAND} state_t;
   state_t state, state_nx;
   logic [31:0] w [TOTAL_WORDS];
   logic [5:0] idx;
   logic [2:0] pos;
   logic [7:0] rcon;
   logic [31:0] prev, sub_in, sub_out, temp, new_word;
   logic [5:0] base;
   logic load, last;
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction
   aes_sbox32 u_sbox (.a(sub_in), .y(sub_out));
   always_comb begin
      load = state == IDLE && start;
      last = state == EXPAND && idx == 6'(TOTAL_WORDS - 1);
      state_nx = load ? EXPAND : last ? IDLE : state;
      prev = w[idx - 6'd1];
      sub_in = pos == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
      temp = pos == 3'd0 ? sub_out ^ {rcon, 24'h0} : (NK == 8 && pos == 3'd4) ? sub_out : prev;
      new_word = w[idx - 6'(NK)] ^ temp;
      base = {rd_round, 2'b00};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (load) for (int k = 0; k < NK; k++) w[k] <= key_in[KEY_BITS-1-32*k -: 32];
      else if (state == EXPAND) w[idx] <= new_word;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         keys_ready <= 1'b0;
         rd_key <= '0;
         rcon <= 8'h01;
         idx <= '0;
         pos <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            busy <= 1'b1;
            keys_ready <= 1'b0;
            rcon <= 8'h01;
            idx <= 6'(NK);
            pos <= '0;
         end else if (state == EXPAND) begin
            idx <= idx + 6'd1;
            pos <= pos == 3'(NK - 1) ? 3'd0 : pos + 3'd1;
            rcon <= pos == 3'd0 ? xtime(rcon) : rcon;
            if (last) begin
               busy <= 1'b0;
               done <= 1'b1;
               keys_ready <= 1'b1;
            end
         end
         rd_key <= keys_ready && rd_round <= 4'(NR) ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
      end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed and random checks of three key-schedule widths against an arithmetic AES model
module tb_aes_key_schedule;
   logic clk = 1'b0;
   logic reset;
   logic start_v [3];
   logic [127:0] key128;
   logic [191:0] key192;
   logic [255:0] key256;
   logic busy_v [3];
   logic done_v [3];
   logic kr_v [3];
   logic [3:0] rd_v [3];
   logic [127:0] rk_v [3];
   int checks = 0;
   int errors = 0;
   int lat [3] = '{40, 46, 52};
   int nk [3] = '{4, 6, 8};
   localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   always #5 clk = ~clk;
   aes_key_schedule #(.KEY_BITS(128)) d128 (.clk(clk), .reset(reset), .start(start_v[0]), .key_in(key128),
      .busy(busy_v[0]), .done(done_v[0]), .keys_ready(kr_v[0]), .rd_round(rd_v[0]), .rd_key(rk_v[0]));
   aes_key_schedule #(.KEY_BITS(192)) d192 (.clk(clk), .reset(reset), .start(start_v[1]), .key_in(key192),
      .busy(busy_v[1]), .done(done_v[1]), .keys_ready(kr_v[1]), .rd_round(rd_v[1]), .rd_key(rk_v[1]));
   aes_key_schedule #(.KEY_BITS(256)) d256 (.clk(clk), .reset(reset), .start(start_v[2]), .key_in(key256),
      .busy(busy_v[2]), .done(done_v[2]), .keys_ready(kr_v[2]), .rd_round(rd_v[2]), .rd_key(rk_v[2]));
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction
   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction
   // S-box from its definition: multiplicative inverse in GF(2^8) (x^254) then the affine map
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction
   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
   endfunction
   // key is left-aligned in 256 bits; returns round key r, or zero beyond the last round
   function automatic logic [127:0] ref_rk(input logic [255:0] key, input int n, input int r);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0] rc = 8'h01;
      if (r > n + 6) return '0;
      for (int i = 0; i < n; i++) w[i] = key[255-32*i -: 32];
      for (int i = n; i < 4 * (n + 7); i++) begin
         t = w[i-1];
         if (i % n == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (n == 8 && i % n == 4) t = subw(t);
         w[i] = w[i-n] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction
   function automatic logic [255:0] key_of(input int s);
      return s == 0 ? {key128, 128'h0} : s == 1 ? {key192, 64'h0} : key256;
   endfunction
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic rand_key(input int s);
      logic [255:0] k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (s == 0) key128 = k[255:128];
      else if (s == 1) key192 = k[255:64];
      else key256 = k;
   endtask
   task automatic start_exp(input int s);
      @(negedge clk);
      start_v[s] = 1'b1;
      @(posedge clk);
      #1 start_v[s] = 1'b0;
   endtask
   task automatic wait_done(input int s, input int n, input string tag);
      int c = 0;
      bit seen = 1'b0;
      while (!seen && c < n + 20) begin
         @(posedge clk);
         #1;
         c++;
         seen = done_v[s];
      end
      check(tag, 128'(seen ? c : -1), 128'(n));
   endtask
   task automatic rd(input int s, input int r, input logic [127:0] exp, input string tag);
      @(negedge clk);
      rd_v[s] = 4'(r);
      @(posedge clk);
      #1 check(tag, rk_v[s], exp);
   endtask
   initial begin
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         start_v[s] = 1'b0;
         rd_v[s] = 4'd0;
      end
      key128 = A1_KEY;
      key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 128'(busy_v[0]), 128'(0));
      check("rst_done", 128'(done_v[0]), 128'(0));
      check("rst_kr", 128'(kr_v[0]), 128'(0));
      check("rst_rdkey", rk_v[0], '0);
      @(negedge clk) reset = 1'b0;
      start_exp(0);
      check("a128_busy", 128'(busy_v[0]), 128'(1));
      wait_done(0, 40, "a128_latency");
      check("a128_kr", 128'(kr_v[0]), 128'(1));
      check("a128_busy_end", 128'(busy_v[0]), 128'(0));
      @(posedge clk);
      #1 check("a128_done_pulse", 128'(done_v[0]), 128'(0));
      rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "a128_r1");
      rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_r10");
      rd(0, 0, A1_KEY, "a128_r0");
      rd(0, 11, '0, "a128_r11");
      rd(0, 15, '0, "a128_r15");
      start_exp(1);
      wait_done(1, 46, "a192_latency");
      rd(1, 12, 128'he98ba06f448c773c8ecc720401002202, "a192_r12");
      rd(1, 13, '0, "a192_r13");
      rd(1, 5, ref_rk(key_of(1), 6, 5), "a192_r5");
      start_exp(2);
      wait_done(2, 52, "a256_latency");
      rd(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, "a256_r14");
      rd(2, 1, key256[127:0], "a256_r1");
      rd(2, 15, '0, "a256_r15");
      start_exp(0);
      repeat (9) @(posedge clk);
      #1;
      rand_key(0);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1 start_v[0] = 1'b0;
      check("ign_busy", 128'(busy_v[0]), 128'(1));
      wait_done(0, 30, "ign_latency");
      rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ign_r10");
      rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "ign_r1");
      key128 = '0;
      start_exp(0);
      check("rs_kr_drop", 128'(kr_v[0]), 128'(0));
      @(posedge clk);
      #1 check("rs_rdkey_busy", rk_v[0], '0);
      wait_done(0, 39, "rs_latency");
      rd(0, 1, 128'h62636363626363636263636362636363, "rs_zero_r1");
      rd(1, 12, 128'he98ba06f448c773c8ecc720401002202, "pre_rst_r12");
      rand_key(0);
      start_exp(0);
      repeat (19) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("ar_busy", 128'(busy_v[0]), 128'(0));
      check("ar_done", 128'(done_v[0]), 128'(0));
      check("ar_kr", 128'(kr_v[0]), 128'(0));
      check("ar_rdkey", rk_v[0], '0);
      check("ar_kr192", 128'(kr_v[1]), 128'(0));
      check("ar_rdkey192", rk_v[1], '0);
      @(negedge clk) reset = 1'b0;
      rand_key(0);
      start_exp(0);
      wait_done(0, 40, "fresh_latency");
      for (int r = 0; r <= 10; r++) rd(0, r, ref_rk(key_of(0), 4, r), $sformatf("fresh_r%0d", r));
      for (int it = 0; it < 3; it++)
         for (int s = 0; s < 3; s++) begin
            int r = $urandom_range(0, 15);
            rand_key(s);
            start_exp(s);
            wait_done(s, lat[s] - 1 + 1, $sformatf("rnd_lat_%0d_%0d", s, it));
            rd(s, r, ref_rk(key_of(s), nk[s], r), $sformatf("rnd_k%0d_it%0d_r%0d", s, it, r));
         end
      rand_key(2);
      @(negedge clk) start_v[2] = 1'b1;
      @(posedge clk);
      #1;
      wait_done(2, 52, "held_latency");
      @(posedge clk);
      #1 check("held_restart_busy", 128'(busy_v[2]), 128'(1));
      start_v[2] = 1'b0;
      wait_done(2, 52, "held_latency2");
      rd(2, 7, ref_rk(key_of(2), 8, 7), "held_r7");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative, parametrised AES key-schedule engine. It supports AES-128, AES-192 and AES-256, selected at elaboration by KEY_BITS. On a start request it expands the cipher key one 32-bit word per clock into an internal round-key store. The cipher datapath then reads any round key by index through a registered read port. It replaces the single-round, AES-128-only on-the-fly expander, so encrypt/decrypt cores can fetch round keys in any order.

Parameters:
KEY_BITS, 128, cipher key width; legal values 128, 192, 256; any other value is an elaboration error.
NK, KEY_BITS/32, derived localparam: key words (4/6/8).
NR, NK+6, derived localparam: number of rounds (10/12/14).
TOTAL_WORDS, 4*(NR+1), derived localparam: schedule words (44/52/60).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  expansion request; sampled only when busy=0
key_in  in  KEY_BITS  cipher key; w[0]=key_in[KEY_BITS-1 -: 32], MSW first; sampled with start
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word has been written
keys_ready  out  1  level; the store holds a complete, valid schedule
rd_round  in  4  round-key index 0..NR
rd_key  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]} for r=rd_round, registered

Behaviour:
- Reset (async, any time, including mid-expansion): state=IDLE, busy=0, done=0, keys_ready=0, rd_key=0, rcon=8'h01, word index=0. The word store need not be cleared, because keys_ready gates reads.
- FSM states: IDLE, EXPAND.
- IDLE, start=1 at edge E0:
  - load w[0..NK-1] from key_in; rcon<=8'h01; i<=NK.
  - busy<=1, keys_ready<=0.
  - go to EXPAND.
- EXPAND: one word per edge. temp=w[i-1].
  - If i mod NK==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon<=xtime(rcon), where xtime(x)={x[6:0],1'b0}^(x[7]?8'h1b:8'h00).
  - Else if NK==8 and i mod NK==4: temp=SubWord(temp).
  - w[i]<=w[i-NK]^temp; i<=i+1.
  - RotWord(a,b,c,d)=(b,c,d,a).
  - SubWord uses the existing 32-bit S-box module (one instance, combinational).
- The last write is i=TOTAL_WORDS-1 at edge E(TOTAL_WORDS-NK). At that same edge: busy<=0, done<=1 (cleared next edge), keys_ready<=1, state<=IDLE.
- Latency from E0 to done high: 40 / 46 / 52 cycles for 128 / 192 / 256.
- start while busy=1: ignored; expansion continues unchanged.
- start in IDLE with keys_ready=1: restart. keys_ready drops at E0 and the old schedule is discarded.
- start held high: one expansion per IDLE visit. A restart happens on the cycle after done, because the FSM is in IDLE then.
- Read port, evaluated every edge:
  - If keys_ready=1 and rd_round<=NR: rd_key<=round key rd_round.
  - Otherwise rd_key<=128'h0.
  - Latency is 1 cycle. rd_round>NR always returns zero.
- key_in changes after E0 have no effect on the expansion in progress.
- No combinational path from any input to any output.

Test Plan:
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle.
  - done exactly 40 cycles after E0.
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=0 -> the key itself.
- AES-192 (KEY_BITS=192), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - done at 46 cycles.
  - rd_round=12 -> e98ba06f448c773c8ecc720401002202.
  - rd_round=13 -> 0.
- AES-256 (KEY_BITS=256), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - done at 52 cycles.
  - rd_round=14 -> fe4890d1e6188d0b046df344706c631e.
  - Exercises the i mod 8==4 SubWord path.
- start pulsed again at cycle 10 of an AES-128 expansion, with a different key_in:
  - ignored; done still at 40.
  - round 10 still matches the A.1 vector.
- Reset asserted at cycle 20 of an expansion:
  - busy, done, keys_ready and rd_key go 0 immediately, with no clock needed.
  - A fresh start after reset release produces a correct schedule.
- Restart with keys_ready=1 using the all-zero key:
  - keys_ready falls at E0 and rd_key reads 0 during busy.
  - After done, round 1 = 62636363626363636263636362636363.
